// File: rtl/spw_buffer_ctrl.sv
// Purpose : slot-based buffer controller; allocates the lowest free slot on write and
//           releases slots in acceptance order through a pointer ring.
// Latency : wr_en_o/rd_en_o are same-cycle; a written entry is readable the next cycle.
// Backpr. : in_ready_o drops when no slot is free (a slot released this cycle is not
//           reusable until the next); out_ready_i is ignored while empty.
//
// Ports   : clk_i, rst_i (async, active-high)
//           in_valid_i / in_ready_o / wr_en_o / write_ptr_o  -- producer side
//           out_valid_o / out_ready_i / rd_en_o / read_ptr_o -- consumer side
//           count_o  -- occupied slots 0..DEPTH
//           hwm_o    -- occupancy high-water mark, only with `SPW_BUFFER_CTRL_HWM_EN
module spw_buffer_ctrl #(
    parameter int PTR_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 wr_en_o,
    output logic [PTR_WIDTH-1:0] write_ptr_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 rd_en_o,
    output logic [PTR_WIDTH-1:0] read_ptr_o,
    output logic [PTR_WIDTH:0]   count_o
`ifdef SPW_BUFFER_CTRL_HWM_EN
    ,
    output logic [PTR_WIDTH:0]   hwm_o
`endif
);
    localparam int DEPTH = 2**PTR_WIDTH;

    logic [DEPTH-1:0]     r_free;
    logic [PTR_WIDTH-1:0] r_ring [DEPTH];
    logic [PTR_WIDTH:0]   r_head;
    logic [PTR_WIDTH:0]   r_tail;

    logic [PTR_WIDTH-1:0] w_low_free;
    logic [PTR_WIDTH:0]   w_count;
    logic                 w_acc;
    logic                 w_pop;

    // Lowest-index free slot: scan from the top so the lowest set bit wins.
    always_comb begin
        w_low_free = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_free[i]) begin
                w_low_free = PTR_WIDTH'(i);
            end
        end
    end

    // Head/tail carry one extra bit so full (diff = DEPTH) and empty (diff = 0) differ.
    assign w_count     = r_tail - r_head;
    assign in_ready_o  = |r_free;
    assign write_ptr_o = w_low_free;
    assign w_acc       = in_valid_i && in_ready_o;
    assign wr_en_o     = w_acc;
    assign out_valid_o = (w_count != '0);
    assign read_ptr_o  = r_ring[r_head[PTR_WIDTH-1:0]];
    assign w_pop       = out_valid_o && out_ready_i;
    assign rd_en_o     = w_pop;
    assign count_o     = w_count;

    // Accepted and popped slots are always distinct (one free, one occupied),
    // so both free-vector updates can apply in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_free <= '1;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_acc) begin
                r_free[w_low_free] <= 1'b0;
                r_tail             <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_free[read_ptr_o] <= 1'b1;
                r_head             <= r_head + 1'b1;
            end
        end
    end

    // Ring contents are only meaningful between head and tail, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (w_acc) begin
            r_ring[r_tail[PTR_WIDTH-1:0]] <= w_low_free;
        end
    end

`ifdef SPW_BUFFER_CTRL_HWM_EN
    logic [PTR_WIDTH:0] r_hwm;
    logic [PTR_WIDTH:0] w_next_count;

    assign w_next_count = w_count + {{PTR_WIDTH{1'b0}}, w_acc} - {{PTR_WIDTH{1'b0}}, w_pop};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hwm <= '0;
        end else if (w_next_count > r_hwm) begin
            r_hwm <= w_next_count;
        end
    end

    assign hwm_o = r_hwm;
`endif

endmodule

// File: tb/tb_spw_buffer_ctrl.sv
// Purpose : self-checking bench for spw_buffer_ctrl (PTR_WIDTH = 3).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpr. : reference model is a slot free-array plus an acceptance-order queue.
module tb_spw_buffer_ctrl;
    localparam int PW    = 3;
    localparam int DEPTH = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          wr_en_o;
    logic [PW-1:0] write_ptr_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          rd_en_o;
    logic [PW-1:0] read_ptr_o;
    logic [PW:0]   count_o;
`ifdef SPW_BUFFER_CTRL_HWM_EN
    logic [PW:0]   hwm_o;
`endif

    spw_buffer_ctrl #(.PTR_WIDTH(PW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .wr_en_o    (wr_en_o),
        .write_ptr_o(write_ptr_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .rd_en_o    (rd_en_o),
        .read_ptr_o (read_ptr_o),
        .count_o    (count_o)
`ifdef SPW_BUFFER_CTRL_HWM_EN
        ,
        .hwm_o      (hwm_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: which slots are free, and the occupied slots in acceptance order.
    bit m_free [DEPTH];
    int m_q [$];
    int m_hwm;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int low_free();
        for (int i = 0; i < DEPTH; i++) begin
            if (m_free[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_free[i] = 1'b1;
        m_q.delete();
        m_hwm = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, int'(in_ready_o), 1);
        check_eq({tag, "_out_valid"}, int'(out_valid_o), 0);
        check_eq({tag, "_wr_en"}, int'(wr_en_o), 0);
        check_eq({tag, "_rd_en"}, int'(rd_en_o), 0);
        check_eq({tag, "_count"}, int'(count_o), 0);
`ifdef SPW_BUFFER_CTRL_HWM_EN
        check_eq({tag, "_hwm"}, int'(hwm_o), 0);
`endif
    endtask

    // Called at edge+1: raise reset between edges, check immediately, release after next edge.
    task automatic pulse_reset(input string tag);
        in_valid_i = 1'b0;
        out_ready_i = $urandom_range(0, 1);
        rst_i = 1'b1;
        #1;
        check_reset_outputs(tag);
        model_clear();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // One clock cycle: drive, compare outputs with the model, advance the model.
    task automatic step(input bit vld, input bit rdy);
        int  lf;
        bit  acc;
        bit  pop;
        int  slot;
        in_valid_i  = vld;
        out_ready_i = rdy;
        #1;
        lf  = low_free();
        acc = vld && (lf >= 0);
        pop = rdy && (m_q.size() != 0);
        check_eq("in_ready", int'(in_ready_o), int'(lf >= 0));
        check_eq("wr_en", int'(wr_en_o), int'(acc));
        if (lf >= 0) check_eq("write_ptr", int'(write_ptr_o), lf);
        check_eq("out_valid", int'(out_valid_o), int'(m_q.size() != 0));
        check_eq("rd_en", int'(rd_en_o), int'(pop));
        if (m_q.size() != 0) check_eq("read_ptr", int'(read_ptr_o), m_q[0]);
        check_eq("count", int'(count_o), m_q.size());
`ifdef SPW_BUFFER_CTRL_HWM_EN
        check_eq("hwm", int'(hwm_o), m_hwm);
`endif
        if (pop) begin
            slot = m_q.pop_front();
            m_free[slot] = 1'b1;
        end
        if (acc) begin
            m_q.push_back(lf);
            m_free[lf] = 1'b0;
        end
        if (m_q.size() > m_hwm) m_hwm = m_q.size();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("rst_hold");
        rst_i = 1'b0;

        // Back-to-back accepts land in slots 0,1,2.
        repeat (3) step(1, 0);
        check_eq("b2b_count", int'(count_o), 3);
        check_eq("b2b_head_slot", int'(read_ptr_o), 0);

        // Fill to 8, then keep pushing against a full buffer.
        repeat (5) step(1, 0);
        check_eq("full_count", int'(count_o), 8);
        repeat (3) step(1, 0);

        // Pop slot 0 while full; that slot is reused one cycle later.
        step(1, 1);
        step(1, 0);
        check_eq("refill_count", int'(count_o), 8);

        // Middle-slot reuse: yields occupancy order 0,2,1 in physical slots.
        pulse_reset("rst_a");
        step(1, 0);
        step(1, 0);
        step(0, 1);
        step(1, 0);
        step(1, 0);
        step(0, 1);
        step(1, 0);
        repeat (4) step(0, 1);

        // Simultaneous accept and pop at count 4 across pointer wrap.
        pulse_reset("rst_b");
        repeat (4) step(1, 0);
        repeat (20) step(1, 1);
        check_eq("steady_count", int'(count_o), 4);
        repeat (5) step(0, 1);

        // Asynchronous reset mid-stream at count 5, then next accept uses slot 0.
        pulse_reset("rst_c");
        repeat (5) step(1, 0);
        pulse_reset("rst_mid");
        step(1, 0);
        check_eq("post_rst_count", int'(count_o), 1);

        // Randomized traffic with varying bias and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            int bias;
            bias = (n / 250) % 3;
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rst_rand");
            end else begin
                step(($urandom_range(0, 3) < 1 + bias), ($urandom_range(0, 3) < 3 - bias));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
